// File: rtl/fft_tw_agu_if.sv
// Butterfly descriptor channel between the twiddle AGU and the butterfly datapath.
interface fft_tw_agu_if #(
    parameter int LOG2N = 10
);
    logic             bf_valid_o;
    logic             bf_ready_i;
    logic [LOG2N-1:0] bf_addr_a_o;
    logic [LOG2N-1:0] bf_addr_b_o;
    logic [31:0]      bf_tw_o;
    logic [3:0]       bf_stage_o;
    logic             bf_stage_last_o;
    logic             bf_last_o;

    modport master (
        output bf_valid_o, bf_addr_a_o, bf_addr_b_o, bf_tw_o,
               bf_stage_o, bf_stage_last_o, bf_last_o,
        input  bf_ready_i
    );

    modport slave (
        input  bf_valid_o, bf_addr_a_o, bf_addr_b_o, bf_tw_o,
               bf_stage_o, bf_stage_last_o, bf_last_o,
        output bf_ready_i
    );
endinterface

// File: rtl/fft_tw_agu.sv
// Radix-2 DIT FFT address generator: walks stages/butterflies, drives the twiddle
// RAM address and hands one butterfly descriptor per handshake downstream.
//
// state    | meaning
// IDLE     | waiting for start_i
// RUN      | loading descriptors whenever the output slot is free
// WAIT_ACK | stage boundary, held until downstream commits the stage
// DRAIN    | final descriptor loaded, waiting for its acceptance
module fft_tw_agu #(
    parameter int LOG2N   = 10,
    parameter int TW_BASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        stage_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] tw_addr_o,
    input  logic [31:0] tw_data_i,
    fft_tw_agu_if.master bf
);
    localparam int             BFW    = LOG2N - 1;
    localparam logic [BFW-1:0] BF_MAX = '1;
    localparam logic [3:0]     S_MAX  = 4'(LOG2N - 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_ACK, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [3:0]       s;
    logic [BFW-1:0]   bf_cnt;
    logic [LOG2N-1:0] bf_ext, half, j, g, a, b, k;
    logic             stage_last, load, accept;

    // Butterfly index -> leg addresses and twiddle exponent for the current stage.
    always_comb begin
        bf_ext = {1'b0, bf_cnt};
        half   = LOG2N'(1) << s;
        j      = bf_ext & (half - LOG2N'(1));
        g      = (bf_ext >> s) << (s + 4'd1);
        a      = g | j;
        b      = a | half;
        k      = j << (S_MAX - s);
    end

    assign stage_last = (bf_cnt == BF_MAX);
    assign tw_addr_o  = 16'(TW_BASE) + 16'(k);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_i) state_nxt = RUN;
            RUN:      if (load && stage_last) state_nxt = (s == S_MAX) ? DRAIN : WAIT_ACK;
            WAIT_ACK: if (stage_ack_i) state_nxt = RUN;
            DRAIN:    if (accept) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
        accept = bf.bf_valid_o && bf.bf_ready_i;
        load   = (state == RUN) && (!bf.bf_valid_o || bf.bf_ready_i);
        done_o = (state == DRAIN) && accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s      <= '0;
            bf_cnt <= '0;
        end else if (state == IDLE && start_i) begin
            s      <= '0;
            bf_cnt <= '0;
        end else if (load) begin
            if (!stage_last) begin
                bf_cnt <= bf_cnt + BFW'(1);
            end else if (s != S_MAX) begin
                bf_cnt <= '0;
                s      <= s + 4'd1;
            end
        end
    end

    // Output slot: refilled on load, emptied on acceptance, frozen under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            bf.bf_valid_o      <= 1'b0;
            bf.bf_addr_a_o     <= '0;
            bf.bf_addr_b_o     <= '0;
            bf.bf_tw_o         <= '0;
            bf.bf_stage_o      <= '0;
            bf.bf_stage_last_o <= 1'b0;
            bf.bf_last_o       <= 1'b0;
        end else if (load) begin
            bf.bf_valid_o      <= 1'b1;
            bf.bf_addr_a_o     <= a;
            bf.bf_addr_b_o     <= b;
            bf.bf_tw_o         <= tw_data_i;
            bf.bf_stage_o      <= s;
            bf.bf_stage_last_o <= stage_last;
            bf.bf_last_o       <= stage_last && (s == S_MAX);
        end else if (accept) begin
            bf.bf_valid_o      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_tw_agu.sv
// Directed bench: 8-point sweeps with backpressure/barrier/restart/reset, plus a 1024-point sweep.
module tb_fft_tw_agu;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s = 1'b1, start_s = 1'b0, ack_s = 1'b0;
    logic        busy_s, done_s;
    logic [15:0] tw_addr_s;
    logic [31:0] tw_data_s;
    fft_tw_agu_if #(.LOG2N(3)) bs();

    logic        rst_g = 1'b1, start_g = 1'b0, ack_g = 1'b0;
    logic        busy_g, done_g;
    logic [15:0] tw_addr_g;
    logic [31:0] tw_data_g;
    fft_tw_agu_if #(.LOG2N(10)) bg();

    assign tw_data_s = 32'h1000_0000 + {16'd0, tw_addr_s};
    assign tw_data_g = 32'h1000_0000 + {16'd0, tw_addr_g - 16'h0100};

    fft_tw_agu #(.LOG2N(3), .TW_BASE(0)) dut_s (
        .clk(clk), .rst(rst_s), .start_i(start_s), .stage_ack_i(ack_s),
        .busy_o(busy_s), .done_o(done_s), .tw_addr_o(tw_addr_s), .tw_data_i(tw_data_s),
        .bf(bs.master)
    );

    fft_tw_agu #(.LOG2N(10), .TW_BASE(16'h0100)) dut_g (
        .clk(clk), .rst(rst_g), .start_i(start_g), .stage_ack_i(ack_g),
        .busy_o(busy_g), .done_o(done_g), .tw_addr_o(tw_addr_g), .tw_data_i(tw_data_g),
        .bf(bg.master)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Hand-computed 8-point schedule (a, b, k) in issue order.
    int exp_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_k[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    function automatic logic [31:0] exp_desc_s(input int n);
        return {20'd0, 4'(n / 4), (n % 4) == 3, n == 11, 3'(exp_a[n]), 3'(exp_b[n])};
    endfunction

    function automatic logic [31:0] obs_desc_s();
        return {20'd0, bs.bf_stage_o, bs.bf_stage_last_o, bs.bf_last_o,
                bs.bf_addr_a_o, bs.bf_addr_b_o};
    endfunction

    task automatic sweep_s(input int bp_idx, input int bp_len, input int ack_dly,
                           input int restart_cyc, input int rst_at, input string nm);
        int  n = 0, held = 0, gap = 0, dones = 0, ack_wait = -1, first_valid = -1;
        bit  in_gap = 1'b0, aborted = 1'b0;
        for (int c = 0; c < 400 && n < 12; c++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && n == rst_at) begin
                rst_s = 1'b1; start_s = 1'b0; ack_s = 1'b0;
                @(posedge clk); #1;
                rst_s = 1'b0;
                @(negedge clk);
                chk({nm, "_rst_valid"}, {31'd0, bs.bf_valid_o}, 32'd0);
                chk({nm, "_rst_busy"}, {31'd0, busy_s}, 32'd0);
                chk({nm, "_rst_twaddr"}, {16'd0, tw_addr_s}, 32'd0);
                chk({nm, "_rst_desc"}, obs_desc_s(), 32'd0);
                aborted = 1'b1;
                break;
            end
            start_s = (c == 0) || (c == restart_cyc);
            bs.bf_ready_i = !(n == bp_idx && held < bp_len);
            ack_s = (ack_wait == 0);
            if (ack_wait >= 0) ack_wait--;
            @(negedge clk);
            if (c == 1) chk({nm, "_busy"}, {31'd0, busy_s}, 32'd1);
            if (bs.bf_valid_o && first_valid < 0) first_valid = c;
            if (done_s) dones++;
            if (in_gap) begin
                if (bs.bf_valid_o) begin
                    chk({nm, "_gap"}, gap, ack_dly + 2);
                    in_gap = 1'b0;
                end else begin
                    gap++;
                end
            end
            if (bs.bf_valid_o) begin
                if (!bs.bf_ready_i) begin
                    held++;
                    chk({nm, "_held_desc"}, obs_desc_s(), exp_desc_s(n));
                    chk({nm, "_held_tw"}, bs.bf_tw_o, 32'h1000_0000 + exp_k[n]);
                end else begin
                    chk({nm, "_desc"}, obs_desc_s(), exp_desc_s(n));
                    chk({nm, "_tw"}, bs.bf_tw_o, 32'h1000_0000 + exp_k[n]);
                    chk({nm, "_done_at"}, {31'd0, done_s}, {31'd0, n == 11});
                    if (n % 4 == 3 && n != 11) begin
                        ack_wait = ack_dly;
                        in_gap = 1'b1;
                        gap = 0;
                    end
                    n++;
                end
            end
        end
        start_s = 1'b0; ack_s = 1'b0; bs.bf_ready_i = 1'b1;
        if (!aborted) begin
            chk({nm, "_count"}, n, 12);
            chk({nm, "_done_cnt"}, dones, 1);
            chk({nm, "_latency"}, first_valid, 2);
            if (bp_idx >= 0) chk({nm, "_bp_held"}, held, bp_len);
            @(negedge clk);
            chk({nm, "_end_busy"}, {31'd0, busy_s}, 32'd0);
            chk({nm, "_end_valid"}, {31'd0, bs.bf_valid_o}, 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    int ga[5120], gb[5120], gk[5120], gs[5120], gj[5120];

    task automatic sweep_g();
        int n = 0, dones = 0, ack_wait = -1, idx = 0;
        for (int s = 0; s < 10; s++) begin
            for (int grp = 0; grp < (512 >> s); grp++) begin
                for (int j = 0; j < (1 << s); j++) begin
                    ga[idx] = grp * 2 * (1 << s) + j;
                    gb[idx] = ga[idx] + (1 << s);
                    gk[idx] = j * (512 >> s);
                    gs[idx] = s;
                    gj[idx] = grp * (1 << s) + j;
                    idx++;
                end
            end
        end
        bg.bf_ready_i = 1'b1;
        for (int c = 0; c < 8000 && n < 5120; c++) begin
            @(posedge clk); #1;
            start_g = (c == 0);
            ack_g = (ack_wait == 0);
            if (ack_wait >= 0) ack_wait--;
            @(negedge clk);
            if (done_g) dones++;
            if (bg.bf_valid_o) begin
                if (n == 5118) chk("big_twaddr_bf511", {16'd0, tw_addr_g}, 32'h0000_02FF);
                chk("big_desc",
                    {6'd0, bg.bf_stage_o, bg.bf_stage_last_o, bg.bf_last_o,
                     bg.bf_addr_a_o, bg.bf_addr_b_o},
                    {6'd0, 4'(gs[n]), gj[n] == 511, n == 5119, 10'(ga[n]), 10'(gb[n])});
                chk("big_tw", bg.bf_tw_o, 32'h1000_0000 + gk[n]);
                if (n == 5119) begin
                    chk("big_last_a", {22'd0, bg.bf_addr_a_o}, 32'd511);
                    chk("big_last_b", {22'd0, bg.bf_addr_b_o}, 32'd1023);
                    chk("big_last_tw", bg.bf_tw_o, 32'h1000_01FF);
                end
                if (gj[n] == 511 && n != 5119) ack_wait = 0;
                n++;
            end
        end
        start_g = 1'b0; ack_g = 1'b0;
        chk("big_count", n, 5120);
        repeat (3) begin
            @(negedge clk);
            if (done_g) dones++;
        end
        chk("big_done_cnt", dones, 1);
        chk("big_end_busy", {31'd0, busy_g}, 32'd0);
    endtask

    initial begin
        bs.bf_ready_i = 1'b1;
        bg.bf_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_s = 1'b0;
        rst_g = 1'b0;
        @(negedge clk);
        chk("reset_valid", {31'd0, bs.bf_valid_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_s}, 32'd0);
        chk("reset_done", {31'd0, done_s}, 32'd0);
        chk("reset_twaddr", {16'd0, tw_addr_s}, 32'd0);
        chk("reset_desc", obs_desc_s(), 32'd0);
        chk("reset_tw", bs.bf_tw_o, 32'd0);
        chk("reset_big_twaddr", {16'd0, tw_addr_g}, 32'h0000_0100);
        chk("reset_big_valid", {31'd0, bg.bf_valid_o}, 32'd0);

        sweep_s(-1, 0, 0, -1, -1, "base");
        sweep_s(1, 5, 0, -1, -1, "bp");
        sweep_s(-1, 0, 10, -1, -1, "barrier");
        sweep_s(-1, 0, 0, 9, -1, "restart");
        sweep_s(-1, 0, 0, -1, 6, "midrst");
        sweep_s(-1, 0, 0, -1, -1, "post");
        sweep_g();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_tw_agu.md
Name: fft_tw_agu

Overview:
- Address generator and twiddle fetch unit for the radix-2 DIT FFT core.
- Walks every stage and every butterfly of an N-point FFT and drives the twiddle RAM read address.
- Captures the combinational twiddle word and presents one butterfly descriptor per handshake to the butterfly datapath: data addresses A/B, twiddle, stage index and last flags.
- Sits directly downstream of the twiddle RAM (reads its data_o) and upstream of the butterfly unit.

Parameters:
- LOG2N, 10, log2 of FFT length N (range 2..10; N/2 twiddles held in RAM).
- TW_BASE, 0, twiddle RAM word address of W_N^0.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  begin a full FFT sweep; honoured only in IDLE.
- stage_ack_i  input  1  downstream has committed all writes of the current stage.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse when the final descriptor is accepted.
- tw_addr_o  output  16  twiddle RAM read address, combinational from internal counters.
- tw_data_i  input  32  twiddle RAM read data, same cycle as tw_addr_o; [31:16] cos, [15:0] -sin, Q1.15.
- bf_valid_o  output  1  descriptor valid.
- bf_ready_i  input  1  downstream accepts descriptor.
- bf_addr_a_o  output  LOG2N  upper-leg data address.
- bf_addr_b_o  output  LOG2N  lower-leg data address.
- bf_tw_o  output  32  twiddle word, passed through unchanged.
- bf_stage_o  output  4  stage index s.
- bf_stage_last_o  output  1  last butterfly of stage s.
- bf_last_o  output  1  last butterfly of the whole FFT.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge, also mid-operation): state=IDLE; counters s=0, bf=0; all outputs 0 (tw_addr_o=TW_BASE); any held descriptor discarded.
- Counters: s in 0..LOG2N-1; bf in 0..N/2-1.
- Per-butterfly arithmetic, all unsigned, exact widths:
  - half = 1<<s
  - j = bf & (half-1)
  - g = (bf>>s)<<(s+1)
  - a = g|j; b = a|half
  - k = j<<(LOG2N-1-s)
  - tw_addr_o = TW_BASE + k, zero-extended to 16 bits; no wrap for legal parameters.
- States:
  - IDLE: start_i -> RUN, s=0, bf=0. start_i while busy_o=1 is ignored.
  - RUN: load condition is (!bf_valid_o || bf_ready_i). On load:
    - output register takes a, b, tw_data_i, s, stage_last=(bf==N/2-1), last=(stage_last && s==LOG2N-1).
    - bf_valid_o=1.
    - If not stage_last: bf++.
    - Else if s<LOG2N-1: bf=0, s++, -> WAIT_ACK.
    - Else: -> DRAIN.
  - WAIT_ACK: no new loads; the held descriptor still drains through the handshake. stage_ack_i=1 -> RUN. An ack arriving while the held descriptor is still valid is allowed (the RUN load rule still applies).
  - DRAIN: when bf_valid_o && bf_ready_i: bf_valid_o=0, done_o=1 for exactly that cycle, -> IDLE.
- Handshake: the descriptor is held stable while bf_valid_o && !bf_ready_i. bf_valid_o never drops without acceptance (except reset).
- Throughput: 1 descriptor/cycle with bf_ready_i tied high, except at stage boundaries.
- Latency: start_i sampled at edge t -> RUN at t+1 -> bf_valid_o=1 after edge t+2.
- stage_ack_i is ignored outside WAIT_ACK.
- tw_data_i is sampled only on load cycles.

Test Plan:
- LOG2N=3, TW_BASE=0, RAM[k]=0x1000_0000+k, ready=1, ack pulsed in WAIT_ACK -> 12 descriptors in order (a,b,k):
  - s0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - s1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - s2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - bf_tw_o=0x1000_000k on each; stage_last on the 4th, 8th and 12th; bf_last_o only on the 12th; done_o one cycle on the 12th acceptance.
- Backpressure: bf_ready_i low for 5 cycles on the 2nd descriptor -> outputs frozen at (2,3,0); no skipped or duplicated descriptors.
- Stage barrier: withhold stage_ack_i for 10 cycles after the s0 boundary -> no s1 descriptor appears until 1 cycle after the ack is sampled.
- start_i re-asserted mid-sweep -> ignored; sequence unchanged. rst asserted mid-s1 -> next cycle bf_valid_o=0, busy_o=0, tw_addr_o=TW_BASE.
- LOG2N=10, TW_BASE=0x100 -> 5120 descriptors total. Last-stage descriptor bf=511 gives a=511, b=1023, tw_addr_o=0x2FF. done_o pulses exactly once.
